apb_controller: RTL and testbench

- Bridge FSM directly upstream of apb_interface.
- Accepts decoded AHB transfers (valid, address, select, write data) from the AHB slave interface.
- Sequences each transfer as an APB SETUP→ACCESS pair: drives Pselx/Paddr/Pwrite/Pwdata/Penable to apb_interface.
- Stalls the AHB side via Hreadyout and returns Prdata to the AHB side as Hrdata.

---
 rtl/bridge_pkg.sv | 21 ++
 rtl/apb_controller.sv | 128 ++++++++++++
 tb/tb_apb_controller.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
// Shared types and defaults for the AHB-to-APB bridge.
// Imported by the controller and by the upstream valid generator.
package bridge_pkg;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_SLAVES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WWAIT  = 2'b01,
    SETUP  = 2'b10,
    ACCESS = 2'b11
  } state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

endpackage

// File: rtl/apb_controller.sv
// AHB-to-APB bridge FSM: turns each accepted AHB transfer
// into an APB SETUP/ACCESS pair, stalling AHB meanwhile.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_SLAVES = DEF_NUM_SLAVES
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic                  valid,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic                  Hwrite,
  input  logic [NUM_SLAVES-1:0] tempselx,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [DATA_WIDTH-1:0] Prdata,
  output logic [NUM_SLAVES-1:0] Pselx,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic                  Pwrite,
  output logic [DATA_WIDTH-1:0] Pwdata,
  output logic                  Penable,
  output logic                  Hreadyout,
  output logic [DATA_WIDTH-1:0] Hrdata
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;
  logic                  pend_write_q, pend_write_d;
  logic [NUM_SLAVES-1:0] pend_sel_q, pend_sel_d;
  logic [DATA_WIDTH-1:0] pend_data_q, pend_data_d;

  logic [NUM_SLAVES-1:0] psel_q, psel_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  penable_q, penable_d;
  logic                  hready_q, hready_d;

  always_comb begin
    state_d      = state_q;
    pend_addr_d  = pend_addr_q;
    pend_write_d = pend_write_q;
    pend_sel_d   = pend_sel_q;
    pend_data_d  = pend_data_q;

    unique case (state_q)
      IDLE, ACCESS: begin
        if (valid) begin
          pend_addr_d  = Haddr;
          pend_write_d = Hwrite;
          pend_sel_d   = tempselx;
          state_d      = Hwrite ? WWAIT : SETUP;
        end else begin
          state_d = IDLE;
        end
      end
      WWAIT: begin
        pend_data_d = Hwdata;
        state_d     = SETUP;
      end
      SETUP:   state_d = ACCESS;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered, so decode them from the next state.
  always_comb begin
    psel_d    = '0;
    penable_d = 1'b0;
    hready_d  = 1'b1;
    paddr_d   = paddr_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;

    unique case (state_d)
      IDLE:  hready_d = 1'b1;
      WWAIT: hready_d = 1'b0;
      SETUP, ACCESS: begin
        psel_d    = pend_sel_d;
        paddr_d   = pend_addr_d;
        pwrite_d  = pend_write_d;
        pwdata_d  = pend_data_d;
        penable_d = (state_d == ACCESS);
        hready_d  = (state_d == ACCESS);
      end
      default: hready_d = 1'b1;
    endcase
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q      <= IDLE;
      pend_addr_q  <= '0;
      pend_write_q <= 1'b0;
      pend_sel_q   <= '0;
      pend_data_q  <= '0;
      psel_q       <= '0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pwdata_q     <= '0;
      penable_q    <= 1'b0;
      hready_q     <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_addr_q  <= pend_addr_d;
      pend_write_q <= pend_write_d;
      pend_sel_q   <= pend_sel_d;
      pend_data_q  <= pend_data_d;
      psel_q       <= psel_d;
      paddr_q      <= paddr_d;
      pwrite_q     <= pwrite_d;
      pwdata_q     <= pwdata_d;
      penable_q    <= penable_d;
      hready_q     <= hready_d;
    end
  end

  assign Pselx     = psel_q;
  assign Paddr     = paddr_q;
  assign Pwrite    = pwrite_q;
  assign Pwdata    = pwdata_q;
  assign Penable   = penable_q;
  assign Hreadyout = hready_q;

  assign Hrdata = (state_q == ACCESS && !pwrite_q) ? Prdata : '0;

endmodule

// File: tb/tb_apb_controller.sv
// Directed self-checking bench for apb_controller.
// Inputs change 1ns after a rising edge; outputs sampled there too.
module tb_apb_controller;

  logic        Hclk;
  logic        Hresetn;
  logic        valid;
  logic [31:0] Haddr;
  logic        Hwrite;
  logic [2:0]  tempselx;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic        Pwrite;
  logic [31:0] Pwdata;
  logic        Penable;
  logic        Hreadyout;
  logic [31:0] Hrdata;

  int checks = 0;
  int errors = 0;

  apb_controller dut (
    .Hclk(Hclk), .Hresetn(Hresetn), .valid(valid),
    .Haddr(Haddr), .Hwrite(Hwrite), .tempselx(tempselx),
    .Hwdata(Hwdata), .Prdata(Prdata), .Pselx(Pselx),
    .Paddr(Paddr), .Pwrite(Pwrite), .Pwdata(Pwdata),
    .Penable(Penable), .Hreadyout(Hreadyout), .Hrdata(Hrdata)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic step();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic test_reset();
    Hresetn = 1'b0; valid = 1'b0; Haddr = '0; Hwrite = 1'b0;
    tempselx = '0; Hwdata = '0; Prdata = '0;
    #12;
    checks++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL rst_out got sel=%b en=%b rdy=%b exp 000/0/1",
               Pselx, Penable, Hreadyout);
    end
    checks++;
    if (Paddr !== 32'h0 || Pwdata !== 32'h0 || Pwrite !== 1'b0) begin
      errors++;
      $display("FAIL rst_reg got a=%h d=%h w=%b exp 0/0/0",
               Paddr, Pwdata, Pwrite);
    end
    @(negedge Hclk);
    Hresetn = 1'b1;
    step();
    step();
    checks++;
    if (Hreadyout !== 1'b1 || Pselx !== 3'b000) begin
      errors++;
      $display("FAIL rst_idle got rdy=%b sel=%b exp 1/000", Hreadyout, Pselx);
    end
  endtask

  task automatic test_read();
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010; tempselx = 3'b001;
    step();
    valid = 1'b0;
    checks++;
    if (Pselx !== 3'b001 || Paddr !== 32'h8000_0010 || Pwrite !== 1'b0 ||
        Penable !== 1'b0 || Hreadyout !== 1'b0) begin
      errors++;
      $display("FAIL rd_setup got sel=%b a=%h w=%b en=%b rdy=%b exp 001/80000010/0/0/0",
               Pselx, Paddr, Pwrite, Penable, Hreadyout);
    end
    Prdata = 32'hCAFE_F00D;
    step();
    checks++;
    if (Penable !== 1'b1 || Hreadyout !== 1'b1 || Pselx !== 3'b001) begin
      errors++;
      $display("FAIL rd_access got en=%b rdy=%b sel=%b exp 1/1/001",
               Penable, Hreadyout, Pselx);
    end
    chk("rd_hrdata", Hrdata, 32'hCAFE_F00D);
    step();
    checks++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL rd_idle got sel=%b en=%b rdy=%b exp 000/0/1",
               Pselx, Penable, Hreadyout);
    end
    chk("rd_idle_hrdata", Hrdata, 32'h0);
    chk("rd_idle_paddr", Paddr, 32'h8000_0010);
  endtask

  task automatic do_write_to_access();
    valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0004; tempselx = 3'b010;
    step();
    valid = 1'b0; Hwdata = 32'hDEAD_BEEF;
    checks++;
    if (Hreadyout !== 1'b0 || Pselx !== 3'b000 || Penable !== 1'b0) begin
      errors++;
      $display("FAIL wr_wwait got rdy=%b sel=%b en=%b exp 0/000/0",
               Hreadyout, Pselx, Penable);
    end
    step();
    Hwdata = 32'h0;
    checks++;
    if (Pselx !== 3'b010 || Paddr !== 32'h8400_0004 || Pwrite !== 1'b1 ||
        Pwdata !== 32'hDEAD_BEEF || Penable !== 1'b0 || Hreadyout !== 1'b0) begin
      errors++;
      $display("FAIL wr_setup got sel=%b a=%h w=%b d=%h en=%b rdy=%b",
               Pselx, Paddr, Pwrite, Pwdata, Penable, Hreadyout);
    end
    Prdata = 32'h5555_AAAA;
    step();
    checks++;
    if (Penable !== 1'b1 || Hreadyout !== 1'b1 || Pselx !== 3'b010) begin
      errors++;
      $display("FAIL wr_access got en=%b rdy=%b sel=%b exp 1/1/010",
               Penable, Hreadyout, Pselx);
    end
    chk("wr_hrdata", Hrdata, 32'h0);
  endtask

  task automatic test_write();
    do_write_to_access();
    step();
    checks++;
    if (Pselx !== 3'b000 || Hreadyout !== 1'b1 || Pwdata !== 32'hDEAD_BEEF ||
        Pwrite !== 1'b1) begin
      errors++;
      $display("FAIL wr_idle got sel=%b rdy=%b d=%h w=%b exp 000/1/deadbeef/1",
               Pselx, Hreadyout, Pwdata, Pwrite);
    end
  endtask

  task automatic test_back_to_back();
    do_write_to_access();
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0000; tempselx = 3'b100;
    step();
    valid = 1'b0;
    checks++;
    if (Pselx !== 3'b100 || Paddr !== 32'h8800_0000 || Pwrite !== 1'b0 ||
        Pwdata !== 32'hDEAD_BEEF || Penable !== 1'b0 || Hreadyout !== 1'b0) begin
      errors++;
      $display("FAIL b2b_setup got sel=%b a=%h w=%b d=%h en=%b rdy=%b",
               Pselx, Paddr, Pwrite, Pwdata, Penable, Hreadyout);
    end
    Prdata = 32'h0BAD_F00D;
    step();
    checks++;
    if (Penable !== 1'b1 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL b2b_access got en=%b rdy=%b exp 1/1", Penable, Hreadyout);
    end
    chk("b2b_hrdata", Hrdata, 32'h0BAD_F00D);
    step();
  endtask

  task automatic test_unselected();
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h9000_0000; tempselx = 3'b000;
    step();
    valid = 1'b0;
    checks++;
    if (Pselx !== 3'b000 || Paddr !== 32'h9000_0000 || Hreadyout !== 1'b0) begin
      errors++;
      $display("FAIL unsel_setup got sel=%b a=%h rdy=%b exp 000/90000000/0",
               Pselx, Paddr, Hreadyout);
    end
    Prdata = 32'h0;
    step();
    checks++;
    if (Pselx !== 3'b000 || Penable !== 1'b1 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL unsel_access got sel=%b en=%b rdy=%b exp 000/1/1",
               Pselx, Penable, Hreadyout);
    end
    chk("unsel_hrdata", Hrdata, 32'h0);
    Prdata = 32'h0000_0077;
    #1;
    chk("unsel_hrdata_pass", Hrdata, 32'h0000_0077);
    step();
  endtask

  task automatic test_spurious_valid();
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0020; tempselx = 3'b001;
    step();
    Haddr = 32'h0000_1234; Hwrite = 1'b1; tempselx = 3'b100;
    step();
    valid = 1'b0;
    checks++;
    if (Paddr !== 32'h8000_0020 || Pwrite !== 1'b0 || Pselx !== 3'b001 ||
        Penable !== 1'b1 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL spur_access got a=%h w=%b sel=%b en=%b rdy=%b",
               Paddr, Pwrite, Pselx, Penable, Hreadyout);
    end
    step();
    checks++;
    if (Pselx !== 3'b000 || Hreadyout !== 1'b1 || Paddr !== 32'h8000_0020) begin
      errors++;
      $display("FAIL spur_idle got sel=%b rdy=%b a=%h exp 000/1/80000020",
               Pselx, Hreadyout, Paddr);
    end
  endtask

  task automatic test_reset_mid_access();
    valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0030; tempselx = 3'b001;
    step();
    valid = 1'b0;
    step();
    chk("mid_pre_en", {31'h0, Penable}, 32'h1);
    #2;
    Hresetn = 1'b0;
    #1;
    checks++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL mid_rst got sel=%b en=%b rdy=%b exp 000/0/1",
               Pselx, Penable, Hreadyout);
    end
    chk("mid_rst_paddr", Paddr, 32'h0);
    chk("mid_rst_pwdata", Pwdata, 32'h0);
    chk("mid_rst_hrdata", Hrdata, 32'h0);
    @(negedge Hclk);
    Hresetn = 1'b1;
    step();
    step();
    checks++;
    if (Pselx !== 3'b000 || Penable !== 1'b0 || Hreadyout !== 1'b1) begin
      errors++;
      $display("FAIL mid_post got sel=%b en=%b rdy=%b exp 000/0/1",
               Pselx, Penable, Hreadyout);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_unselected();
    test_spurious_valid();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
